bundle_binarizer: RTL and testbench

BUNDLE_BINARIZER -- requirements
Module: bundle_binarizer

---
 rtl/hypercorex_pkg.sv | 15 +
 rtl/lfsr_tiebreak.sv | 34 +++
 rtl/bundle_binarizer.sv | 128 ++++++++++++
 tb/tb_bundle_binarizer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/hypercorex_pkg.sv
// Shared types and constants for the bundle binarizer: FSM state encoding,
// tie-break LFSR polynomial taps (x^32+x^22+x^2+x+1) and default seed.
package hypercorex_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } bin_state_e;

  // Bit i set means state bit i feeds the XOR; covers exponents 32, 22, 2 and 1.
  localparam logic [31:0] LfsrTaps        = 32'h8020_0003;
  localparam logic [31:0] LfsrDefaultSeed = 32'hACE1_0001;

endpackage

// File: rtl/lfsr_tiebreak.sv
// 32-bit Fibonacci LFSR supplying tie-break bits; advances one step per
// enabled cycle, no backpressure; async active-high reset reloads the seed.
module lfsr_tiebreak
  import hypercorex_pkg::*;
#(
  parameter logic [31:0] Seed = LfsrDefaultSeed
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [31:0] state_o
);

  logic [31:0] lfsr_d;
  logic [31:0] lfsr_q;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {lfsr_q[30:0], ^(lfsr_q & LfsrTaps)};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/bundle_binarizer.sv
// Thresholds bundler counters into a binary hypervector, ChunkWidth dims per cycle;
// result valid NumChunks cycles after start, held until hv_ready_i, then clears the bundler.
module bundle_binarizer
  import hypercorex_pkg::*;
#(
  parameter int          HVDimension  = 512,
  parameter int          CounterWidth = 8,
  parameter int          ChunkWidth   = 64,
  parameter logic [31:0] LfsrSeed     = LfsrDefaultSeed
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic signed [HVDimension-1:0][CounterWidth-1:0] counter_i,
  input  logic signed [CounterWidth-1:0]                 threshold_i,
  input  logic                                           start_i,
  output logic                                           busy_o,
  output logic [HVDimension-1:0]                         hv_o,
  output logic                                           hv_valid_o,
  input  logic                                           hv_ready_i,
  output logic                                           bundler_clr_o
);

  localparam int NumChunks = HVDimension / ChunkWidth;
  localparam int ChunkIdxW = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam logic [ChunkIdxW-1:0] LastChunk = ChunkIdxW'(NumChunks - 1);

  bin_state_e                state_d, state_q;
  logic [ChunkIdxW-1:0]      chunk_d, chunk_q;
  logic [HVDimension-1:0]    hv_d, hv_q;
  logic                      clr_d, clr_q;
  logic                      lfsr_en;
  logic [31:0]               lfsr_state;

  logic [ChunkWidth-1:0][CounterWidth-1:0] chunk_cnt;
  logic [ChunkWidth-1:0]                   chunk_bits;

  lfsr_tiebreak #(
    .Seed (LfsrSeed)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (lfsr_en),
    .state_o (lfsr_state)
  );

  // Only one chunk of counters is compared per cycle, so mux the counters down first.
  always_comb begin
    chunk_cnt = '0;
    for (int k = 0; k < NumChunks; k++) begin
      if (chunk_q == ChunkIdxW'(k)) begin
        chunk_cnt = counter_i[k*ChunkWidth +: ChunkWidth];
      end
    end
  end

  always_comb begin
    chunk_bits = '0;
    for (int j = 0; j < ChunkWidth; j++) begin
      if ($signed(chunk_cnt[j]) > threshold_i) begin
        chunk_bits[j] = 1'b1;
      end else if ($signed(chunk_cnt[j]) < threshold_i) begin
        chunk_bits[j] = 1'b0;
      end else begin
        chunk_bits[j] = lfsr_state[j % 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    chunk_d = chunk_q;
    hv_d    = hv_q;
    clr_d   = 1'b0;
    lfsr_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SCAN;
          chunk_d = '0;
        end
      end
      ST_SCAN: begin
        for (int k = 0; k < NumChunks; k++) begin
          if (chunk_q == ChunkIdxW'(k)) begin
            hv_d[k*ChunkWidth +: ChunkWidth] = chunk_bits;
          end
        end
        // LFSR state used above is the pre-step value; it steps at this same edge.
        lfsr_en = 1'b1;
        if (chunk_q == LastChunk) begin
          state_d = ST_HOLD;
          chunk_d = '0;
        end else begin
          chunk_d = chunk_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (hv_ready_i) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      chunk_q <= '0;
      hv_q    <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      hv_q    <= hv_d;
      clr_q   <= clr_d;
    end
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign hv_valid_o    = (state_q == ST_HOLD);
  assign hv_o          = hv_q;
  assign bundler_clr_o = clr_q;

endmodule

// File: tb/tb_bundle_binarizer.sv
// Directed, table-driven bench for bundle_binarizer (512 dims, 64 per chunk, 8-bit counters)
// with a reference LFSR model for tie bits and hand sequences for reset and ignored start.
module tb_bundle_binarizer;

  localparam int          HV   = 512;
  localparam int          CW   = 8;
  localparam int          CH   = 64;
  localparam logic [31:0] SEED = 32'hACE1_0001;

  logic                         clk_i = 1'b0;
  logic                         rst_i;
  logic signed [HV-1:0][CW-1:0] counter_i;
  logic signed [CW-1:0]         threshold_i;
  logic                         start_i;
  logic                         busy_o;
  logic [HV-1:0]                hv_o;
  logic                         hv_valid_o;
  logic                         hv_ready_i;
  logic                         bundler_clr_o;

  always #5 clk_i = ~clk_i;

  bundle_binarizer #(
    .HVDimension  (HV),
    .CounterWidth (CW),
    .ChunkWidth   (CH),
    .LfsrSeed     (SEED)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .counter_i     (counter_i),
    .threshold_i   (threshold_i),
    .start_i       (start_i),
    .busy_o        (busy_o),
    .hv_o          (hv_o),
    .hv_valid_o    (hv_valid_o),
    .hv_ready_i    (hv_ready_i),
    .bundler_clr_o (bundler_clr_o)
  );

  typedef struct {
    logic signed [CW-1:0] a;      // value for even dims
    logic signed [CW-1:0] b;      // value for odd dims
    logic signed [CW-1:0] thr;
    int                   delay;  // cycles hv_ready_i stays low in HOLD
    logic [HV-1:0]        ones;   // dims expected to be 1
    logic [HV-1:0]        tie;    // dims expected to take the LFSR tie bit
  } vec_t;

  vec_t        vecs[8];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl_lfsr;

  task automatic chk(input string name, input logic [HV-1:0] act, input logic [HV-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // Tie bits of one full scan; advances the model by one step per chunk.
  task automatic tie_bits(output logic [HV-1:0] t);
    t = '0;
    for (int k = 0; k < HV / CH; k++) begin
      for (int j = 0; j < CH; j++) t[k*CH + j] = mdl_lfsr[j % 32];
      mdl_lfsr = lfsr_step(mdl_lfsr);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_cnt(input logic signed [CW-1:0] a, input logic signed [CW-1:0] b,
                         input logic signed [CW-1:0] thr);
    for (int d = 0; d < HV; d++) counter_i[d] = (d % 2 == 0) ? a : b;
    threshold_i = thr;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [HV-1:0] t;
    logic [HV-1:0] exp;
    logic          busy_ok;
    int            cyc;
    set_cnt(v.a, v.b, v.thr);
    tie_bits(t);
    exp = v.ones | (v.tie & t);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    cyc     = 0;
    busy_ok = 1'b1;
    while (!hv_valid_o && cyc < 20) begin
      busy_ok &= busy_o;
      tick();
      cyc++;
    end
    chk($sformatf("v%0d_latency", idx), HV'(cyc), HV'(8));
    chk($sformatf("v%0d_busy_scan", idx), HV'(busy_ok), HV'(1));
    chk($sformatf("v%0d_hv", idx), hv_o, exp);
    for (int c = 0; c < v.delay; c++) begin
      tick();
      chk($sformatf("v%0d_hold_hv_c%0d", idx, c), hv_o, exp);
      chk($sformatf("v%0d_hold_ctl_c%0d", idx, c),
          HV'({hv_valid_o, busy_o, bundler_clr_o}), HV'(3'b110));
    end
    hv_ready_i = 1'b1;
    tick();
    hv_ready_i = 1'b0;
    chk($sformatf("v%0d_clr_pulse", idx),
        HV'({hv_valid_o, busy_o, bundler_clr_o}), HV'(3'b001));
    chk($sformatf("v%0d_hv_idle", idx), hv_o, exp);
    tick();
    chk($sformatf("v%0d_clr_end", idx),
        HV'({hv_valid_o, busy_o, bundler_clr_o}), HV'(3'b000));
  endtask

  initial begin
    logic [HV-1:0] scratch;
    int            cyc;

    vecs[0] = '{a:  8'sd3,   b:  8'sd3,   thr:  8'sd0,   delay: 0,
                ones: {HV{1'b1}}, tie: '0};
    vecs[1] = '{a:  8'sd1,   b: -8'sd1,   thr:  8'sd0,   delay: 5,
                ones: {256{2'b01}}, tie: '0};
    vecs[2] = '{a:  8'sd0,   b:  8'sd0,   thr:  8'sd0,   delay: 1,
                ones: '0, tie: {HV{1'b1}}};
    vecs[3] = '{a: -8'sd128, b: -8'sd128, thr: -8'sd128, delay: 0,
                ones: '0, tie: {HV{1'b1}}};
    vecs[4] = '{a: -8'sd128, b: -8'sd128, thr:  8'sd127, delay: 2,
                ones: '0, tie: '0};
    vecs[5] = '{a:  8'sd4,   b:  8'sd4,   thr:  8'sd5,   delay: 0,
                ones: '0, tie: '0};
    vecs[6] = '{a:  8'sd5,   b: -8'sd7,   thr: -8'sd7,   delay: 1,
                ones: {256{2'b01}}, tie: {256{2'b10}}};
    vecs[7] = '{a:  8'sd127, b:  8'sd127, thr: -8'sd128, delay: 0,
                ones: {HV{1'b1}}, tie: '0};

    rst_i       = 1'b1;
    start_i     = 1'b0;
    hv_ready_i  = 1'b0;
    counter_i   = '0;
    threshold_i = '0;
    mdl_lfsr    = SEED;
    tick();
    tick();
    rst_i = 1'b0;
    chk("reset_outs", HV'({hv_valid_o, busy_o, bundler_clr_o}), HV'(3'b000));
    chk("reset_hv", hv_o, '0);
    chk("reset_lfsr", HV'(dut.u_lfsr.lfsr_q), HV'(SEED));

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Asynchronous reset mid-cycle with a nonzero result held in hv_o.
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("arst_outs", HV'({hv_valid_o, busy_o, bundler_clr_o}), HV'(3'b000));
    chk("arst_hv", hv_o, '0);
    chk("arst_lfsr", HV'(dut.u_lfsr.lfsr_q), HV'(SEED));
    tick();
    rst_i    = 1'b0;
    mdl_lfsr = SEED;

    // start_i pulsed during SCAN is ignored; hv_ready_i in IDLE has no effect.
    set_cnt(8'sd3, 8'sd3, 8'sd0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    cyc = 3;
    while (!hv_valid_o && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("ign_latency", HV'(cyc), HV'(8));
    chk("ign_hv", hv_o, {HV{1'b1}});
    tie_bits(scratch);
    hv_ready_i = 1'b1;
    tick();
    chk("ign_clr", HV'(bundler_clr_o), HV'(1));
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("ign_idle_c%0d", c),
          HV'({hv_valid_o, busy_o, bundler_clr_o}), HV'(3'b000));
    end
    hv_ready_i = 1'b0;

    // Reset during SCAN aborts without a clear pulse and restarts the LFSR.
    set_cnt(8'sd0, 8'sd0, 8'sd0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    tick();
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("scan_rst_outs", HV'({hv_valid_o, busy_o, bundler_clr_o}), HV'(3'b000));
    chk("scan_rst_hv", hv_o, '0);
    tick();
    rst_i    = 1'b0;
    mdl_lfsr = SEED;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("scan_rst_idle_c%0d", c),
          HV'({hv_valid_o, busy_o, bundler_clr_o}), HV'(3'b000));
    end
    run_vec(vecs[2], 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
